llc_mem_responder: RTL and testbench

Memory-side responder for the LLC memory interface: accepts line-granularity read/write requests issued by the LLC on its memory request channel and returns read data on the memory response channel. It sits between the LLC and the testbench/FPGA memory model, replacing the ad-hoc DRAM stub with a cycle-deterministic, fixed-latency backing store. One request is in flight at a time, matching the LLC's single outstanding memory access.

---
 rtl/llc_mem_pkg.sv | 20 ++
 rtl/llc_mem_responder_if.sv | 35 +++
 rtl/llc_mem_array.sv | 43 ++++
 rtl/llc_mem_responder.sv | 123 ++++++++++++
 tb/tb_llc_mem_responder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/llc_mem_pkg.sv
// llc_mem_pkg
//   Shared definitions for the LLC memory-side responder: responder state
//   encoding, default line/address widths and the read-latency counter width.
//   No ports (package).
package llc_mem_pkg;

  localparam int DEF_LINE_WIDTH      = 128;
  localparam int DEF_LINE_ADDR_WIDTH = 28;

  // Wide enough to hold READ_LATENCY-2 for the largest legal latency (15).
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    RSP_ST_IDLE      = 2'd0,
    RSP_ST_WRITE     = 2'd1,
    RSP_ST_READ_WAIT = 2'd2,
    RSP_ST_RSP       = 2'd3
  } rsp_state_e;

endpackage

// File: rtl/llc_mem_responder_if.sv
// llc_mem_responder_if
//   LLC memory request/response channel bundle.
//   master : LLC side (drives requests, consumes read responses)
//   slave  : responder side (accepts requests, returns read data)
//   Signals: req_valid/ready handshake with hwrite, hsize, hprot, addr, line;
//            rsp_valid/ready handshake with rsp_line.
interface llc_mem_responder_if #(
  parameter int LINE_WIDTH      = 128,
  parameter int LINE_ADDR_WIDTH = 28
);
  logic                       llc_mem_req_valid;
  logic                       llc_mem_req_ready;
  logic                       llc_mem_req_hwrite;
  logic [2:0]                 llc_mem_req_hsize;
  logic [1:0]                 llc_mem_req_hprot;
  logic [LINE_ADDR_WIDTH-1:0] llc_mem_req_addr;
  logic [LINE_WIDTH-1:0]      llc_mem_req_line;
  logic                       llc_mem_rsp_valid;
  logic                       llc_mem_rsp_ready;
  logic [LINE_WIDTH-1:0]      llc_mem_rsp_line;

  modport master (
    output llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_hsize,
           llc_mem_req_hprot, llc_mem_req_addr, llc_mem_req_line,
           llc_mem_rsp_ready,
    input  llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line
  );

  modport slave (
    input  llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_hsize,
           llc_mem_req_hprot, llc_mem_req_addr, llc_mem_req_line,
           llc_mem_rsp_ready,
    output llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line
  );
endinterface

// File: rtl/llc_mem_array.sv
// llc_mem_array
//   Synchronous 1R1W line store with a per-line valid bit. Data is not reset;
//   the valid vector is, so lines never written since reset read as zero.
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     we, waddr,     write strobe, line index, write data
//     wdata
//     re, raddr      read strobe and line index
//     rdata          registered read data (zero if line invalid), held when re=0
module llc_mem_array #(
  parameter int LINE_WIDTH = 128,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [LINE_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [LINE_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [LINE_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      vld;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     vld <= '0;
    else if (we) vld[waddr] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= vld[raddr] ? mem[raddr] : '0;
  end

endmodule

// File: rtl/llc_mem_responder.sv
// llc_mem_responder
//   Fixed-latency backing store for the LLC memory channel. One request in
//   flight; writes complete silently, reads answer READ_LATENCY cycles after
//   accept and hold their data under back-pressure.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     mem_if (slave)    request/response channel (see llc_mem_responder_if)
//     mem_rd_count      accepted-read count   (only with LLC_MEM_COUNTERS_EN)
//     mem_wr_count      accepted-write count  (only with LLC_MEM_COUNTERS_EN)
//   Build option: define LLC_MEM_COUNTERS_EN to add the statistics counters.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | ready for a request
//   WRITE     | committing latched line to the array
//   READ_WAIT | array read issued, latency counter running down to zero
//   RSP       | read data presented, waiting for rsp_ready
module llc_mem_responder
  import llc_mem_pkg::*;
#(
  parameter int LINE_WIDTH      = DEF_LINE_WIDTH,
  parameter int LINE_ADDR_WIDTH = DEF_LINE_ADDR_WIDTH,
  parameter int DEPTH_LOG2      = 10,
  parameter int READ_LATENCY    = 4
) (
  input  logic               clk,
  input  logic               rst,
  llc_mem_responder_if.slave mem_if
`ifdef LLC_MEM_COUNTERS_EN
  ,
  output logic [31:0]        mem_rd_count,
  output logic [31:0]        mem_wr_count
`endif
);

  localparam logic [1:0] S_IDLE      = RSP_ST_IDLE;
  localparam logic [1:0] S_WRITE     = RSP_ST_WRITE;
  localparam logic [1:0] S_READ_WAIT = RSP_ST_READ_WAIT;
  localparam logic [1:0] S_RSP       = RSP_ST_RSP;

  // One cycle goes to the accept edge and one to the registered array read.
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LATENCY - 2);

  logic [1:0]            state_q;
  logic [LAT_CNT_W-1:0]  cnt_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic                  req_fire;
  logic                  arr_we;
  logic                  arr_re;

  // Gated by rst so the channel reads not-ready and idle during the reset cycle.
  assign mem_if.llc_mem_req_ready = (state_q == S_IDLE) & ~rst;
  assign mem_if.llc_mem_rsp_valid = (state_q == S_RSP) & ~rst;
  assign req_fire = mem_if.llc_mem_req_valid & mem_if.llc_mem_req_ready;

  // A reset landing on the WRITE cycle must not commit the line.
  assign arr_we = (state_q == S_WRITE) & ~rst;
  assign arr_re = (state_q == S_READ_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_fire) begin
            addr_q  <= mem_if.llc_mem_req_addr[DEPTH_LOG2-1:0];
            line_q  <= mem_if.llc_mem_req_line;
            cnt_q   <= LAT_LOAD;
            state_q <= mem_if.llc_mem_req_hwrite ? S_WRITE : S_READ_WAIT;
          end
        end
        S_WRITE: state_q <= S_IDLE;
        S_READ_WAIT: begin
          if (cnt_q == '0) state_q <= S_RSP;
          else             cnt_q   <= cnt_q - LAT_CNT_W'(1);
        end
        S_RSP: begin
          if (mem_if.llc_mem_rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Array output register doubles as rsp_line: it only reloads in READ_WAIT,
  // so data stays put for the whole RSP phase.
  llc_mem_array #(
    .LINE_WIDTH (LINE_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .waddr (addr_q),
    .wdata (line_q),
    .re    (arr_re),
    .raddr (addr_q),
    .rdata (mem_if.llc_mem_rsp_line)
  );

`ifdef LLC_MEM_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_count <= '0;
      mem_wr_count <= '0;
    end else if (req_fire) begin
      if (mem_if.llc_mem_req_hwrite) mem_wr_count <= mem_wr_count + 32'd1;
      else                           mem_rd_count <= mem_rd_count + 32'd1;
    end
  end
`endif

  // Size/protection and the aliased upper address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{mem_if.llc_mem_req_hsize, mem_if.llc_mem_req_hprot,
                       mem_if.llc_mem_req_addr[LINE_ADDR_WIDTH-1:DEPTH_LOG2]};

endmodule

// File: tb/tb_llc_mem_responder.sv
// tb_llc_mem_responder
//   Directed + randomized bench for llc_mem_responder with an associative
//   array line model. Build option: LLC_MEM_COUNTERS_EN also checks counters.
module tb_llc_mem_responder;

  localparam int LW  = 128;
  localparam int AW  = 28;
  localparam int DL  = 10;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  llc_mem_responder_if #(.LINE_WIDTH(LW), .LINE_ADDR_WIDTH(AW)) mem_if ();

`ifdef LLC_MEM_COUNTERS_EN
  logic [31:0] mem_rd_count;
  logic [31:0] mem_wr_count;
`endif

  llc_mem_responder #(
    .LINE_WIDTH      (LW),
    .LINE_ADDR_WIDTH (AW),
    .DEPTH_LOG2      (DL),
    .READ_LATENCY    (LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mem_if (mem_if)
`ifdef LLC_MEM_COUNTERS_EN
    ,
    .mem_rd_count (mem_rd_count),
    .mem_wr_count (mem_wr_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [LW-1:0] ref_line [int];
  int exp_rd = 0;
  int exp_wr = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] model_read(input logic [AW-1:0] addr);
    int idx;
    idx = int'(addr) % (1 << DL);
    return ref_line.exists(idx) ? ref_line[idx] : '0;
  endfunction

  task automatic model_reset();
    ref_line.delete();
    exp_rd = 0;
    exp_wr = 0;
  endtask

  // Waits for req_ready, presents one request for a single accept edge.
  task automatic issue(input logic hw, input logic [AW-1:0] addr, input logic [LW-1:0] line);
    int n;
    n = 0;
    while (!mem_if.llc_mem_req_ready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) chk("req_ready_timeout", 1'b0, 1'b1);
    mem_if.llc_mem_req_valid  = 1'b1;
    mem_if.llc_mem_req_hwrite = hw;
    mem_if.llc_mem_req_hsize  = 3'($urandom_range(0, 7));
    mem_if.llc_mem_req_hprot  = 2'($urandom_range(0, 3));
    mem_if.llc_mem_req_addr   = addr;
    mem_if.llc_mem_req_line   = line;
    step();
    mem_if.llc_mem_req_valid  = 1'b0;
    mem_if.llc_mem_req_line   = {4{$urandom()}};
    if (hw) exp_wr++;
    else    exp_rd++;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] line);
    issue(1'b1, addr, line);
    ref_line[int'(addr) % (1 << DL)] = line;
    chk("wr_ready_low", mem_if.llc_mem_req_ready, 1'b0);
    chk("wr_no_rsp", mem_if.llc_mem_rsp_valid, 1'b0);
    step();
    chk("wr_ready_back", mem_if.llc_mem_req_ready, 1'b1);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int hold);
    logic [LW-1:0] exp;
    logic [LW-1:0] line0;
    int cyc;
    int vcnt;
    exp = model_read(addr);
    mem_if.llc_mem_rsp_ready = (hold == 0);
    issue(1'b0, addr, '0);
    cyc = 1;
    while (!mem_if.llc_mem_rsp_valid && cyc < 40) begin
      chk("rd_wait_ready_low", mem_if.llc_mem_req_ready, 1'b0);
      step();
      cyc++;
    end
    chk("rd_latency", LW'(cyc), LW'(LAT));
    line0 = mem_if.llc_mem_rsp_line;
    chk("rd_data", line0, exp);
    vcnt = 0;
    while (mem_if.llc_mem_rsp_valid && vcnt < hold + 5) begin
      if (vcnt == hold) mem_if.llc_mem_rsp_ready = 1'b1;
      chk("rsp_line_stable", mem_if.llc_mem_rsp_line, line0);
      chk("rsp_ready_low", mem_if.llc_mem_req_ready, 1'b0);
      vcnt++;
      step();
    end
    mem_if.llc_mem_rsp_ready = 1'b1;
    chk("rsp_valid_cycles", LW'(vcnt), LW'(hold + 1));
    chk("rd_ready_after_hs", mem_if.llc_mem_req_ready, 1'b1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    chk("rst_ready_low", mem_if.llc_mem_req_ready, 1'b0);
    chk("rst_rsp_low", mem_if.llc_mem_rsp_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", mem_if.llc_mem_req_ready, 1'b1);
    model_reset();
  endtask

`ifdef LLC_MEM_COUNTERS_EN
  task automatic chk_counters();
    chk("rd_count", LW'(mem_rd_count), LW'(exp_rd));
    chk("wr_count", LW'(mem_wr_count), LW'(exp_wr));
  endtask
`endif

  initial begin
    logic [AW-1:0] a;
    mem_if.llc_mem_req_valid  = 1'b0;
    mem_if.llc_mem_req_hwrite = 1'b0;
    mem_if.llc_mem_req_hsize  = '0;
    mem_if.llc_mem_req_hprot  = '0;
    mem_if.llc_mem_req_addr   = '0;
    mem_if.llc_mem_req_line   = '0;
    mem_if.llc_mem_rsp_ready  = 1'b1;

    rst = 1'b1;
    step();
    step();
    chk("reset_req_ready", mem_if.llc_mem_req_ready, 1'b0);
    chk("reset_rsp_valid", mem_if.llc_mem_rsp_valid, 1'b0);
    chk("reset_rsp_line", mem_if.llc_mem_rsp_line, '0);
    rst = 1'b0;
    #1;
    chk("reset_ready_after", mem_if.llc_mem_req_ready, 1'b1);
    model_reset();

    do_read(28'h5, 0);
    do_write(28'h12, 128'hDEADBEEF_0000_0001_CAFEF00D_12345678);
    do_read(28'h12, 0);
    chk("directed_line_12", model_read(28'h12), 128'hDEADBEEF_0000_0001_CAFEF00D_12345678);
    do_write(28'h3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    do_read(28'h403, 0);
    do_read(28'h12, 7);
`ifdef LLC_MEM_COUNTERS_EN
    chk_counters();
`endif

    // Reset while a read is in READ_WAIT: response dropped, all lines invalid.
    mem_if.llc_mem_rsp_ready = 1'b1;
    issue(1'b0, 28'h12, '0);
    pulse_rst();
    for (int i = 0; i < LAT + 2; i++) begin
      chk("dropped_read_no_rsp", mem_if.llc_mem_rsp_valid, 1'b0);
      step();
    end
    do_read(28'h12, 0);
    do_read(28'h3, 0);

    // Reset on the WRITE cycle: the line must not be committed.
    do_write(28'h21, 128'h1111);
    issue(1'b1, 28'h20, 128'hABCD_0000_0000_0000_0000_0000_0000_1234);
    pulse_rst();
    do_read(28'h20, 0);
    do_read(28'h21, 0);

    for (int i = 0; i < 80; i++) begin
      a = {18'($urandom()), 10'($urandom_range(0, 7))};
      if ($urandom_range(0, 1) == 1) do_write(a, {$urandom(), $urandom(), $urandom(), $urandom()});
      else                           do_read(a, $urandom_range(0, 3));
    end

`ifdef LLC_MEM_COUNTERS_EN
    pulse_rst();
    chk_counters();
    do_write(28'h1, 128'h1);
    do_write(28'h2, 128'h2);
    do_write(28'h3, 128'h3);
    do_read(28'h1, 0);
    do_read(28'h2, 0);
    chk("wr_count_3", LW'(mem_wr_count), LW'(3));
    chk("rd_count_2", LW'(mem_rd_count), LW'(2));
    pulse_rst();
    chk("wr_count_clr", LW'(mem_wr_count), '0);
    chk("rd_count_clr", LW'(mem_rd_count), '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
